mem_access_unit: RTL and testbench

- Load/store sequencer between the EX/MEM pipeline register and data_mem.
- Converts byte-addressed byte/halfword/word requests into word accesses on data_mem's 11-bit word address and 33-bit data port.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Produces a valid/ready handshake so the pipeline stalls while an access is in flight.

---
 rtl/mem_access_pkg.sv | 19 +
 rtl/mem_lane_align.sv | 34 +++
 rtl/mem_access_unit.sv | 109 ++++++++++
 tb/tb_mem_access_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// mem_access_pkg: shared encodings for the load/store sequencer and its lane aligner.
package mem_access_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: little-endian lane extraction with sign/zero extension, and sub-word store merge.
module mem_lane_align
    import mem_access_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        size,
    input  logic [1:0]        lane,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] old_word,
    input  logic [DATA_W-1:0] new_data,
    output logic [DATA_W-1:0] load_data,
    output logic [DATA_W-1:0] merged
);
    logic [BYTE_W-1:0] byte_v;
    logic [HALF_W-1:0] half_v;

    assign byte_v = lane == LANE0 ? old_word[7:0]   :
                    lane == LANE1 ? old_word[15:8]  :
                    lane == LANE2 ? old_word[23:16] : old_word[31:24];
    assign half_v = lane[1] ? old_word[31:16] : old_word[15:0];

    assign load_data = size == SZ_BYTE ? {{(DATA_W-BYTE_W){!is_unsigned && byte_v[BYTE_W-1]}}, byte_v} :
                       size == SZ_HALF ? {{(DATA_W-HALF_W){!is_unsigned && half_v[HALF_W-1]}}, half_v} :
                       old_word;

    always_comb begin
        merged = old_word;
        if (size == SZ_BYTE) merged[{lane, 3'b000} +: BYTE_W] = new_data[BYTE_W-1:0];
        else if (size == SZ_HALF) merged[{lane[1], 4'b0000} +: HALF_W] = new_data[HALF_W-1:0];
        else merged = new_data;
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer turning byte/half/word requests into data_mem word accesses,
// with read-modify-write for sub-word stores and a valid/ready handshake toward the pipeline.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W:0]   mem_in_data,
    input  logic [DATA_W:0]   mem_out_data
);
    state_e            state;
    logic              r_write;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [1:0]        r_lane;
    logic [DATA_W-1:0] r_wdata;
    logic              req_err;
    logic              word_store;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] merged;
    logic              unused_msb;

    assign unused_msb = mem_out_data[DATA_W];
    assign req_ready  = state == IDLE;
    assign word_store = r_write && r_size == SZ_WORD;

    assign req_err = req_size == SZ_ILL ||
                     (req_size == SZ_HALF && req_addr[0]) ||
                     (req_size == SZ_WORD && req_addr[1:0] != 2'b00) ||
                     (req_addr >> (ADDR_W + 2)) != '0;

    // Strobes decode from state so the WAIT-cycle merge can use this cycle's read data;
    // reset gates them so an aborted access never writes.
    assign mem_write   = !reset && r_write && ((state == ISSUE && r_size == SZ_WORD) || state == WAIT);
    assign mem_read    = !reset && state == ISSUE && !word_store;
    assign mem_in_data = mem_write ? {1'b0, state == WAIT ? merged : r_wdata} : '0;

    mem_lane_align #(.DATA_W(DATA_W)) u_align (
        .size        (r_size),
        .lane        (r_lane),
        .is_unsigned (r_unsigned),
        .old_word    (mem_out_data[DATA_W-1:0]),
        .new_data    (r_wdata),
        .load_data   (load_data),
        .merged      (merged)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            resp_valid  <= 1'b0;
            resp_error  <= 1'b0;
            resp_rdata  <= '0;
            mem_address <= '0;
            r_write     <= 1'b0;
            r_unsigned  <= 1'b0;
            r_size      <= SZ_BYTE;
            r_lane      <= LANE0;
            r_wdata     <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    r_write     <= req_write;
                    r_unsigned  <= req_unsigned;
                    r_size      <= req_size;
                    r_lane      <= req_addr[1:0];
                    r_wdata     <= req_wdata;
                    mem_address <= req_addr[ADDR_W+1:2];
                    resp_valid  <= req_err;
                    resp_error  <= req_err;
                    state       <= req_err ? RESP : ISSUE;
                end
                ISSUE: begin
                    resp_valid <= word_store;
                    state      <= word_store ? RESP : WAIT;
                end
                WAIT: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= r_write ? '0 : load_data;
                    state      <= RESP;
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store sequence against a data_mem model, scored by a byte-array reference.
module tb_mem_access_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic [10:0] mem_address;
    logic        mem_write;
    logic        mem_read;
    logic [32:0] mem_in_data;
    logic [32:0] mem_out_data = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sbq[$];
    logic [32:0] mem [0:2047] = '{default: '0};
    logic [7:0]  shadow [0:8191] = '{default: '0};
    int          vectors = 0;
    int          miscompares = 0;
    int          mem_ops = 0;
    int          resp_cnt = 0;
    logic [10:0] last_addr;
    logic        last_rd;

    always #5 clock = ~clock;

    mem_access_unit dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_error   (resp_error),
        .mem_address  (mem_address),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_in_data  (mem_in_data),
        .mem_out_data (mem_out_data)
    );

    always @(posedge clock) begin
        if (mem_write) mem[mem_address] <= mem_in_data;
        if (mem_read) mem_out_data <= mem[mem_address];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_err(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || a >= 32'h2000;
    endfunction

    // Reference: byte-addressed shadow memory; pushes the expected response and latency.
    task automatic model(input logic w, input logic [1:0] sz, input logic u,
                         input logic [31:0] a, input logic [31:0] d, output int lat);
        exp_t        e;
        int          n;
        logic [31:0] v;
        e.err   = is_err(sz, a);
        e.rdata = '0;
        n = sz == 2'b00 ? 1 : sz == 2'b01 ? 2 : 4;
        if (e.err) lat = 1;
        else if (w) begin
            for (int i = 0; i < n; i++) shadow[13'(a + 32'(i))] = d[8*i +: 8];
            lat = n == 4 ? 2 : 3;
        end else begin
            v = '0;
            for (int i = 0; i < n; i++) v[8*i +: 8] = shadow[13'(a + 32'(i))];
            if (!u && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
            e.rdata = v;
            lat = 3;
        end
        sbq.push_back(e);
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (mem_write || mem_read) mem_ops++;
        if (mem_write) chk("in_data_msb", {63'd0, mem_in_data[32]}, 64'd0);
        if (resp_valid) begin
            resp_cnt++;
            if (sbq.size() == 0) chk("unexpected_resp", {63'd0, resp_valid}, 64'd0);
            else begin
                e = sbq.pop_front();
                chk("rdata", {32'd0, resp_rdata}, {32'd0, e.rdata});
                chk("error", {63'd0, resp_error}, {63'd0, e.err});
                chk("ready_in_resp", {63'd0, req_ready}, 64'd0);
            end
        end
    end

    task automatic xact(input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d);
        int k;
        int lat;
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = d;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clock); #1; k++; end
        chk("accept", {63'd0, req_ready}, 64'd1);
        model(w, sz, u, a, d, lat);
        @(posedge clock); #1;
        req_valid = 1'b0;
        last_addr = mem_address;
        last_rd   = mem_read;
        k = 1;
        while (!resp_valid && k < 8) begin @(posedge clock); #1; k++; end
        chk("latency", 64'(k), 64'(lat));
    endtask

    task automatic err_xact(input logic w, input logic [1:0] sz, input logic [31:0] a);
        int ops0;
        ops0 = mem_ops;
        xact(w, sz, 1'b0, a, 32'hFFFF_FFFF);
        @(negedge clock);
        chk("err_no_mem_ops", 64'(mem_ops), 64'(ops0));
    endtask

    initial begin
        logic [31:0] b2b_addr [3];
        logic [1:0]  b2b_size [3];
        logic        b2b_uns  [3];
        int          k;
        int          lat;
        int          c0;
        b2b_addr = '{32'h24, 32'h13, 32'h26};
        b2b_size = '{2'b10, 2'b00, 2'b01};
        b2b_uns  = '{1'b0, 1'b0, 1'b1};
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_error", {63'd0, resp_error}, 64'd0);
        chk("rst_resp_rdata", {32'd0, resp_rdata}, 64'd0);
        chk("rst_mem_address", {53'd0, mem_address}, 64'd0);
        chk("rst_mem_strobes", {62'd0, mem_write, mem_read}, 64'd0);
        chk("rst_mem_in_data", {31'd0, mem_in_data}, 64'd0);
        chk("rst_ready", {63'd0, req_ready}, 64'd1);

        xact(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        chk("load_mem_address", {53'd0, last_addr}, 64'd4);
        chk("load_mem_read", {63'd0, last_rd}, 64'd1);
        xact(1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_0080);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        xact(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        xact(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        xact(1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
        xact(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_1234);
        xact(1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        xact(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        xact(1'b0, 2'b01, 1'b0, 32'h10, 32'h0);
        xact(1'b0, 2'b01, 1'b1, 32'h10, 32'h0);

        err_xact(1'b0, 2'b10, 32'h11);
        err_xact(1'b1, 2'b01, 32'h03);
        err_xact(1'b0, 2'b11, 32'h00);
        err_xact(1'b0, 2'b10, 32'h2000);

        // Abort a byte store in its WAIT cycle; memory must stay untouched.
        @(posedge clock); #1;
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'hAB;
        @(posedge clock); #1;
        req_valid = 1'b0;
        chk("abort_issue_read", {63'd0, mem_read}, 64'd1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1 chk("abort_write_gated", {63'd0, mem_write}, 64'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_idle", {63'd0, req_ready}, 64'd1);
        chk("abort_resp", {63'd0, resp_valid}, 64'd0);
        xact(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

        xact(1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFE_F00D);
        @(posedge clock); #1;
        c0 = resp_cnt;
        req_valid = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_addr = b2b_addr[i]; req_size = b2b_size[i]; req_unsigned = b2b_uns[i];
            model(1'b0, b2b_size[i], b2b_uns[i], b2b_addr[i], 32'h0, lat);
            k = 0;
            while (!req_ready && k < 20) begin @(posedge clock); #1; k++; end
            chk("b2b_accept", {63'd0, req_ready}, 64'd1);
            @(posedge clock); #1;
            chk("b2b_busy", {63'd0, req_ready}, 64'd0);
        end
        req_valid = 1'b0;
        k = 0;
        while (sbq.size() != 0 && k < 20) begin @(posedge clock); #1; k++; end
        repeat (3) @(posedge clock);
        #1;
        chk("b2b_pulses", 64'(resp_cnt - c0), 64'd3);
        chk("sb_drained", 64'(sbq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
